// File: rtl/isp_pkg.sv
// Shared fixed-point helpers for the ISP pixel-processing blocks.
package isp_pkg;

  localparam int NUM_CH = 3;

  // Gain value representing exactly 1.0 for a given number of fraction bits.
  function automatic logic [31:0] unity_gain(input int unsigned gfw);
    return 32'd1 << gfw;
  endfunction

  // Half an LSB of the fractional part, used for round-half-up.
  function automatic logic [31:0] round_const(input int unsigned gfw);
    return (gfw == 0) ? 32'd0 : (32'd1 << (gfw - 1));
  endfunction

endpackage

// File: rtl/isp_wb_chan.sv
// One colour channel of the white-balance gain: multiply in stage 1,
// round half-up, saturate and flag clipping in stage 2.
module isp_wb_chan
  import isp_pkg::*;
#(
  parameter int DW  = 8,
  parameter int GIW = 4,
  parameter int GFW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW-1:0]      pix,
  input  logic [GIW+GFW-1:0] gain,
  input  logic               bypass,
  output logic [DW-1:0]      pix_out,
  output logic               clip
);

  localparam int GW = GIW + GFW;
  localparam int PW = DW + GW;
  localparam logic [PW:0] RND = (PW+1)'(round_const(GFW));

  logic [PW-1:0]   prod_q;
  logic [DW-1:0]   pix_q;
  logic            bypass_q;
  logic [PW-GFW:0] scaled;
  logic            over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      pix_q    <= '0;
      bypass_q <= 1'b0;
    end else begin
      prod_q   <= PW'(pix) * PW'(gain);
      pix_q    <= pix;
      bypass_q <= bypass;
    end
  end

  // The extra top bit keeps the rounding add from wrapping at maximum gain.
  assign scaled = (PW-GFW+1)'(({1'b0, prod_q} + RND) >> GFW);
  assign over   = |scaled[PW-GFW:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out <= '0;
      clip    <= 1'b0;
    end else if (bypass_q) begin
      pix_out <= pix_q;
      clip    <= 1'b0;
    end else begin
      pix_out <= over ? {DW{1'b1}} : scaled[DW-1:0];
      clip    <= over;
    end
  end

endmodule

// File: rtl/isp_wb_gain.sv
// White-balance gain stage: per-channel fixed-point gain with frame-synchronous
// gain updates and per-frame clip statistics.
module isp_wb_gain
  import isp_pkg::*;
#(
  parameter int DW  = 8,
  parameter int GIW = 4,
  parameter int GFW = 12,
  parameter int CW  = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3*DW-1:0]            per_img_data,
  input  logic                       per_img_clken,
  input  logic                       in_href,
  input  logic                       in_vsync,
  input  logic [GIW+GFW-1:0]         gain_r,
  input  logic [GIW+GFW-1:0]         gain_g,
  input  logic [GIW+GFW-1:0]         gain_b,
  input  logic                       gain_upd,
  input  logic                       bypass,
  output logic [3*DW-1:0]            post_img_data,
  output logic                       post_img_clken,
  output logic                       out_href,
  output logic                       out_vsync,
  output logic [CW-1:0]              clip_cnt_r,
  output logic [CW-1:0]              clip_cnt_g,
  output logic [CW-1:0]              clip_cnt_b,
  output logic [3*(GIW+GFW)-1:0]     gain_active
);

  localparam int GW = GIW + GFW;
  localparam logic [GW-1:0] UNITY   = GW'(unity_gain(GFW));
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [GW-1:0]     gain_in    [NUM_CH];
  logic [GW-1:0]     gain_stage [NUM_CH];
  logic [GW-1:0]     gain_act   [NUM_CH];
  logic              gain_pending;
  logic              vsync_prev;
  logic              vs_rise;
  logic              count_armed;
  logic [1:0]        clken_d;
  logic [1:0]        href_d;
  logic [1:0]        vsync_d;
  logic [DW-1:0]     chan_out   [NUM_CH];
  logic [NUM_CH-1:0] chan_clip;
  logic [NUM_CH-1:0] clip_hit;
  logic [CW-1:0]     run_cnt    [NUM_CH];
  logic [CW-1:0]     frame_cnt  [NUM_CH];

  assign gain_in[0] = gain_r;
  assign gain_in[1] = gain_g;
  assign gain_in[2] = gain_b;

  assign vs_rise = in_vsync & ~vsync_prev;

  // Shadow gains: staged anytime, promoted to active only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev   <= 1'b0;
      gain_pending <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        gain_stage[c] <= UNITY;
        gain_act[c]   <= UNITY;
      end
    end else begin
      vsync_prev <= in_vsync;
      for (int c = 0; c < NUM_CH; c++) begin
        if (gain_upd) gain_stage[c] <= gain_in[c];
        if (vs_rise) begin
          if (gain_upd)          gain_act[c] <= gain_in[c];
          else if (gain_pending) gain_act[c] <= gain_stage[c];
        end
      end
      if (vs_rise)       gain_pending <= 1'b0;
      else if (gain_upd) gain_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clken_d <= '0;
      href_d  <= '0;
      vsync_d <= '0;
    end else begin
      clken_d <= {clken_d[0], per_img_clken};
      href_d  <= {href_d[0], in_href};
      vsync_d <= {vsync_d[0], in_vsync};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    isp_wb_chan #(
      .DW  (DW),
      .GIW (GIW),
      .GFW (GFW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .pix     (per_img_data[(NUM_CH-1-c)*DW +: DW]),
      .gain    (gain_act[c]),
      .bypass  (bypass),
      .pix_out (chan_out[c]),
      .clip    (chan_clip[c])
    );
  end

  assign clip_hit = chan_clip & {NUM_CH{clken_d[1]}};

  // Counting stays disarmed after reset until the first frame boundary, so a
  // partial frame never contributes to the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_armed <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        run_cnt[c]   <= '0;
        frame_cnt[c] <= '0;
      end
    end else begin
      if (vs_rise) count_armed <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (vs_rise) begin
          frame_cnt[c] <= run_cnt[c];
          run_cnt[c]   <= CW'(clip_hit[c]);
        end else if (count_armed && clip_hit[c] && (run_cnt[c] != CNT_MAX)) begin
          run_cnt[c] <= run_cnt[c] + CW'(1);
        end
      end
    end
  end

  assign post_img_data  = {chan_out[0], chan_out[1], chan_out[2]};
  assign post_img_clken = clken_d[1];
  assign out_href       = href_d[1];
  assign out_vsync      = vsync_d[1];
  assign clip_cnt_r     = frame_cnt[0];
  assign clip_cnt_g     = frame_cnt[1];
  assign clip_cnt_b     = frame_cnt[2];
  assign gain_active    = {gain_act[0], gain_act[1], gain_act[2]};

endmodule

// File: tb/tb_isp_wb_gain.sv
// Self-checking bench for isp_wb_gain: directed table, hand sequences and
// randomized frames against a cycle-level arithmetic reference model.
`timescale 1ns/1ps
module tb_isp_wb_gain;

  localparam int DW  = 8;
  localparam int GIW = 4;
  localparam int GFW = 12;
  localparam int CW  = 22;
  localparam int GW  = GIW + GFW;
  localparam logic [GW-1:0] UNITY = 16'h1000;
  localparam int PMAX = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3*DW-1:0]   per_img_data = '0;
  logic              per_img_clken = 1'b0;
  logic              in_href = 1'b0;
  logic              in_vsync = 1'b0;
  logic [GW-1:0]     gain_r = 16'h1000;
  logic [GW-1:0]     gain_g = 16'h1000;
  logic [GW-1:0]     gain_b = 16'h1000;
  logic              gain_upd = 1'b0;
  logic              bypass = 1'b0;
  logic [3*DW-1:0]   post_img_data;
  logic              post_img_clken;
  logic              out_href;
  logic              out_vsync;
  logic [CW-1:0]     clip_cnt_r;
  logic [CW-1:0]     clip_cnt_g;
  logic [CW-1:0]     clip_cnt_b;
  logic [3*GW-1:0]   gain_active;

  always #5 clk = ~clk;

  isp_wb_gain #(.DW(DW), .GIW(GIW), .GFW(GFW), .CW(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_img_data   (per_img_data),
    .per_img_clken  (per_img_clken),
    .in_href        (in_href),
    .in_vsync       (in_vsync),
    .gain_r         (gain_r),
    .gain_g         (gain_g),
    .gain_b         (gain_b),
    .gain_upd       (gain_upd),
    .bypass         (bypass),
    .post_img_data  (post_img_data),
    .post_img_clken (post_img_clken),
    .out_href       (out_href),
    .out_vsync      (out_vsync),
    .clip_cnt_r     (clip_cnt_r),
    .clip_cnt_g     (clip_cnt_g),
    .clip_cnt_b     (clip_cnt_b),
    .gain_active    (gain_active)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: one entry per pixel in flight, plus frame bookkeeping.
  typedef struct packed {
    logic [2:0][DW-1:0] pix;
    logic [2:0]         clip;
    logic               clken;
    logic               href;
    logic               vsync;
  } pipe_t;

  pipe_t  m_cur, m_prev;
  int     m_active [3];
  int     m_stage  [3];
  bit     m_pending, m_vprev, m_armed;
  longint m_run [3];
  longint m_cnt [3];
  longint cnt_max;

  typedef struct {
    logic [GW-1:0] gr, gg, gb;
    logic          byp;
    logic [DW-1:0] pr, pg, pb;
    logic [DW-1:0] er, eg, eb;
    logic [CW-1:0] cr, cg, cb;
  } rec_t;

  rec_t tbl [8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int inPix(input int c);
    return int'(per_img_data[(2-c)*DW +: DW]);
  endfunction

  function automatic int inGain(input int c);
    case (c)
      0:       return int'(gain_r);
      1:       return int'(gain_g);
      default: return int'(gain_b);
    endcase
  endfunction

  task automatic modelReset();
    m_cur = '0;
    m_prev = '0;
    m_pending = 0;
    m_vprev = 0;
    m_armed = 0;
    for (int c = 0; c < 3; c++) begin
      m_active[c] = int'(UNITY);
      m_stage[c]  = int'(UNITY);
      m_run[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic modelEdge();
    pipe_t e;
    bit    rise, hit;
    int    p, raw;
    rise = in_vsync && !m_vprev;
    for (int c = 0; c < 3; c++) begin
      hit = m_cur.clken && m_cur.clip[c];
      if (rise) begin
        m_cnt[c] = m_run[c];
        m_run[c] = hit ? 1 : 0;
      end else if (m_armed && hit && m_run[c] < cnt_max) begin
        m_run[c]++;
      end
    end
    if (rise) m_armed = 1;
    e = '0;
    e.clken = per_img_clken;
    e.href  = in_href;
    e.vsync = in_vsync;
    for (int c = 0; c < 3; c++) begin
      p   = inPix(c);
      raw = (p * m_active[c] + (1 << (GFW - 1))) / (1 << GFW);
      if (bypass) begin
        e.pix[c] = DW'(p);
      end else if (raw > PMAX) begin
        e.pix[c]  = DW'(PMAX);
        e.clip[c] = 1'b1;
      end else begin
        e.pix[c] = DW'(raw);
      end
    end
    if (rise) begin
      for (int c = 0; c < 3; c++) begin
        if (gain_upd)       m_active[c] = inGain(c);
        else if (m_pending) m_active[c] = m_stage[c];
      end
      m_pending = 0;
    end else if (gain_upd) begin
      m_pending = 1;
    end
    if (gain_upd) for (int c = 0; c < 3; c++) m_stage[c] = inGain(c);
    m_vprev = in_vsync;
    m_cur  = m_prev;
    m_prev = e;
  endtask

  task automatic compareAll();
    checkOutput("post_clken", 64'(post_img_clken), 64'(m_cur.clken));
    checkOutput("out_href", 64'(out_href), 64'(m_cur.href));
    checkOutput("out_vsync", 64'(out_vsync), 64'(m_cur.vsync));
    if (m_cur.clken)
      checkOutput("post_data", 64'(post_img_data), 64'({m_cur.pix[0], m_cur.pix[1], m_cur.pix[2]}));
    checkOutput("clip_cnt_r", 64'(clip_cnt_r), 64'(m_cnt[0]));
    checkOutput("clip_cnt_g", 64'(clip_cnt_g), 64'(m_cnt[1]));
    checkOutput("clip_cnt_b", 64'(clip_cnt_b), 64'(m_cnt[2]));
    checkOutput("gain_active", 64'(gain_active),
                64'({GW'(m_active[0]), GW'(m_active[1]), GW'(m_active[2])}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    else        modelEdge();
    compareAll();
  endtask

  task automatic applyStimulus(input int pr, input int pg, input int pb, input bit ck,
                               input bit hr, input bit vs, input bit upd, input bit byp);
    per_img_data  = {DW'(pr), DW'(pg), DW'(pb)};
    per_img_clken = ck;
    in_href       = hr;
    in_vsync      = vs;
    gain_upd      = upd;
    bypass        = byp;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadGains(input logic [GW-1:0] gr, input logic [GW-1:0] gg, input logic [GW-1:0] gb);
    gain_r = gr;
    gain_g = gg;
    gain_b = gb;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic runTable();
    for (int i = 0; i < 8; i++) begin
      loadGains(tbl[i].gr, tbl[i].gg, tbl[i].gb);
      applyStimulus(tbl[i].pr, tbl[i].pg, tbl[i].pb, 1, 1, 0, 0, tbl[i].byp);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput($sformatf("tbl%0d_clken", i), 64'(post_img_clken), 64'(1));
      checkOutput($sformatf("tbl%0d_data", i), 64'(post_img_data), 64'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
      idle(1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("tbl%0d_clip_r", i), 64'(clip_cnt_r), 64'(tbl[i].cr));
      checkOutput($sformatf("tbl%0d_clip_g", i), 64'(clip_cnt_g), 64'(tbl[i].cg));
      checkOutput($sformatf("tbl%0d_clip_b", i), 64'(clip_cnt_b), 64'(tbl[i].cb));
      idle(1);
    end
  endtask

  task automatic runShadowGains();
    loadGains(16'h1000, 16'h1000, 16'h1000);
    idle(1);
    gain_r = 16'h1800;
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("mid_upd_active", 64'(gain_active), 64'(48'h1000_1000_1000));
    applyStimulus(101, 50, 60, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mid_upd_old_gain", 64'(post_img_data), 64'({8'd101, 8'd50, 8'd60}));
    idle(1);
    checkOutput("pre_rise_active", 64'(gain_active), 64'(48'h1000_1000_1000));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("at_rise_active", 64'(gain_active), 64'(48'h1800_1000_1000));
    applyStimulus(101, 50, 60, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("new_gain_round", 64'(post_img_data), 64'({8'd152, 8'd50, 8'd60}));
    idle(1);
    gain_b = 16'h2000;
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("coincident_upd", 64'(gain_active), 64'(48'h1800_1000_2000));
    idle(1);
    gain_b = 16'h3000;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("no_pending_left", 64'(gain_active), 64'(48'h1800_1000_2000));
    idle(1);
  endtask

  task automatic runResetMidFrame();
    loadGains(16'h2000, 16'h2000, 16'h2000);
    repeat (3) applyStimulus(200, 200, 200, 1, 1, 0, 0, 0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("pre_rst_clip_r", 64'(clip_cnt_r), 64'(3));
    idle(1);
    applyStimulus(200, 200, 200, 1, 1, 0, 0, 0);
    applyStimulus(200, 200, 200, 1, 1, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_data", 64'(post_img_data), 64'(0));
    checkOutput("rst_clken", 64'(post_img_clken), 64'(0));
    checkOutput("rst_href", 64'(out_href), 64'(0));
    checkOutput("rst_vsync", 64'(out_vsync), 64'(0));
    checkOutput("rst_clip_r", 64'(clip_cnt_r), 64'(0));
    checkOutput("rst_clip_g", 64'(clip_cnt_g), 64'(0));
    checkOutput("rst_clip_b", 64'(clip_cnt_b), 64'(0));
    checkOutput("rst_gain_active", 64'(gain_active), 64'({3{UNITY}}));
    applyStimulus(200, 200, 200, 1, 1, 0, 0, 0);
    applyStimulus(200, 200, 200, 1, 1, 0, 0, 0);
    rst_n = 1'b1;
    idle(3);
    checkOutput("post_rst_clip_g", 64'(clip_cnt_g), 64'(0));
    checkOutput("post_rst_active", 64'(gain_active), 64'({3{UNITY}}));
    applyStimulus(100, 150, 200, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("post_rst_unity", 64'(post_img_data), 64'({8'd100, 8'd150, 8'd200}));
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("post_rst_latch_r", 64'(clip_cnt_r), 64'(0));
    idle(1);
  endtask

  task automatic randomGains();
    gain_r = GW'($urandom_range(0, 32'h3000));
    gain_g = GW'($urandom_range(0, 32'h3000));
    gain_b = GW'($urandom_range(0, 32'h3000));
  endtask

  task automatic runRandom();
    bit byp, upd;
    byp = 0;
    for (int f = 0; f < 6; f++) begin
      for (int v = 0; v < 3; v++) begin
        upd = ($urandom_range(0, 3) == 0);
        if (upd) randomGains();
        applyStimulus(0, 0, 0, 0, 0, 1, upd, byp);
      end
      for (int l = 0; l < 8; l++) begin
        if ($urandom_range(0, 3) == 0) byp = ~byp;
        for (int x = 0; x < 40; x++) begin
          upd = ($urandom_range(0, 59) == 0);
          if (upd) randomGains();
          applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                        ($urandom_range(0, 3) != 0), 1, 0, upd, byp);
        end
        for (int x = 0; x < 5; x++) applyStimulus(0, 0, 0, 0, 0, 0, 0, byp);
      end
    end
  endtask

  initial begin
    cnt_max = (longint'(1) << CW) - 1;
    tbl[0] = '{16'h1000, 16'h1000, 16'h1000, 1'b0, 8'd100, 8'd150, 8'd200, 8'd100, 8'd150, 8'd200, 22'd0, 22'd0, 22'd0};
    tbl[1] = '{16'h1800, 16'h1000, 16'h1000, 1'b0, 8'd101, 8'd50,  8'd60,  8'd152, 8'd50,  8'd60,  22'd0, 22'd0, 22'd0};
    tbl[2] = '{16'h1000, 16'h2000, 16'h1000, 1'b0, 8'd10,  8'd200, 8'd20,  8'd10,  8'd255, 8'd20,  22'd0, 22'd1, 22'd0};
    tbl[3] = '{16'h1000, 16'h2000, 16'h1000, 1'b1, 8'd10,  8'd200, 8'd20,  8'd10,  8'd200, 8'd20,  22'd0, 22'd0, 22'd0};
    tbl[4] = '{16'h0800, 16'h0800, 16'h1000, 1'b0, 8'd1,   8'd3,   8'd255, 8'd1,   8'd2,   8'd255, 22'd0, 22'd0, 22'd0};
    tbl[5] = '{16'h1001, 16'h1009, 16'hFFFF, 1'b0, 8'd255, 8'd255, 8'd0,   8'd255, 8'd255, 8'd0,   22'd0, 22'd1, 22'd0};
    tbl[6] = '{16'h2000, 16'h2000, 16'h2000, 1'b0, 8'd200, 8'd200, 8'd200, 8'd255, 8'd255, 8'd255, 22'd1, 22'd1, 22'd1};
    tbl[7] = '{16'h0000, 16'h1000, 16'h1000, 1'b0, 8'd255, 8'd128, 8'd0,   8'd0,   8'd128, 8'd0,   22'd0, 22'd0, 22'd0};

    modelReset();
    repeat (3) step();
    rst_n = 1'b1;
    $display("[TB] reset released, running directed table");
    runTable();
    runShadowGains();
    runResetMidFrame();
    $display("[TB] running randomized frames");
    runRandom();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isp_wb_gain.md
ISP_WB_GAIN -- requirements
Module: isp_wb_gain

Interface
REQ-001 SHALL have parameter DW, default 8: bits per colour channel.
REQ-002 SHALL have parameter GIW, default 4: integer bits of each gain.
REQ-003 SHALL have parameter GFW, default 12: fractional bits of each gain.
REQ-004 SHALL have parameter CW, default 22: width of each clip counter.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port per_img_data, input, 3*DW: input pixel as {R,G,B}, with R in the MSBs.
REQ-008 SHALL have port per_img_clken, input, 1: input pixel valid.
REQ-009 SHALL have port in_href, input, 1: line-active strobe.
REQ-010 SHALL have port in_vsync, input, 1: frame sync; a rising edge marks the frame boundary.
REQ-011 SHALL have ports gain_r, gain_g and gain_b, input, GIW+GFW each: unsigned fixed-point gains.
REQ-012 SHALL have port gain_upd, input, 1: one-cycle pulse that stages the gain inputs.
REQ-013 SHALL have port bypass, input, 1: when 1, pixels pass through unmodified.
REQ-014 SHALL have port post_img_data, output, 3*DW: output pixel as {R,G,B}.
REQ-015 SHALL have port post_img_clken, output, 1: output pixel valid.
REQ-016 SHALL have ports out_href and out_vsync, output, 1 each: delayed sync signals.
REQ-017 SHALL have ports clip_cnt_r, clip_cnt_g and clip_cnt_b, output, CW each: clipped-pixel counts for the previous frame.
REQ-018 SHALL have port gain_active, output, 3*(GIW+GFW): the gain set currently applied, as {R,G,B}.

Function
REQ-019 SHALL give data, clken, href and vsync the same fixed latency of 2 cycles, input to output.
REQ-020 SHALL compute each channel product as pixel*gain at full width DW+GIW+GFW in stage 1.
REQ-021 SHALL round half-up in stage 2 by adding 2^(GFW-1) and then dropping GFW LSBs.
REQ-022 SHALL saturate any rounded result above 2^DW-1 to 2^DW-1, and flag that channel as clipped.
REQ-023 SHALL forward the input pixel unchanged with the same 2-cycle latency when bypass=1; bypass SHALL be sampled in stage 1.
REQ-024 SHALL never flag a clip while bypass=1.
REQ-025 SHALL use double-buffered gains:
  - gain_upd copies gain_r/g/b into staging registers and sets a pending flag;
  - on an in_vsync rising edge with pending set, staging copies to active and pending clears.
REQ-026 SHALL, when gain_upd coincides with the vsync rising edge, send the new input gains directly to active and leave pending clear.
REQ-027 SHALL use only active gains for multiplication; mid-frame gain_upd SHALL have no effect on the current frame.
REQ-028 SHALL increment a per-channel running clip counter for each valid, clipped, non-bypass pixel.
REQ-029 SHALL hold each running clip counter at 2^CW-1 instead of wrapping.
REQ-030 SHALL, on an in_vsync rising edge, copy the running counters to clip_cnt_* and clear them.
REQ-031 SHALL, when a clip coincides with the vsync rising edge, count that clip in the new frame.
REQ-032 SHALL detect vsync edges with a registered previous-value flop; rst_n resets that flop to 0.
REQ-033 SHALL drive stage registers even when clken=0, while counters advance only on valid pixels.
REQ-034 SHALL produce a defined output on every cycle; post_img_data is don't-care when post_img_clken=0.

Reset
REQ-035 SHALL, on rst_n low, immediately clear all pipeline registers, post_img_*, out_href, out_vsync, clip_cnt_*, the running counters and pending.
REQ-036 SHALL reset active and staging gains to unity, 1<<GFW.
REQ-037 SHALL, on reset release mid-frame, start clean: nothing is counted until the next in_vsync rising edge latches its results.

Structure
REQ-038 SHALL take the unity gain and rounding constant from the shared isp_pkg package, where they are defined as GFW-parameterised functions.
REQ-039 SHALL implement one sub-module, isp_wb_chan, instantiated three times: one channel's multiply, round, saturate and clip flag.
REQ-040 SHALL keep the shadow-gain logic, the sync delay line and the counters in the top level.

Verification
REQ-041 SHALL cover unity gains with input {100,150,200} -> output {100,150,200} 2 cycles later, and zero clips.
REQ-042 SHALL cover gain_r=0x1800 (1.5) staged, then vsync rise, then R=101 -> R out=152 (151.5 rounded up).
REQ-043 SHALL cover gain_g=0x2000 (2.0) with G=200 -> G out=255, clip_cnt_g=1 after the next vsync rise.
REQ-044 SHALL cover a mid-frame gain_upd -> current-frame outputs still use the old gain; gain_active changes exactly at the next vsync rise.
REQ-045 SHALL cover bypass=1 with gain 2.0 and G=200 -> G out=200, and no clip counted.
REQ-046 SHALL cover rst_n pulsed low mid-frame -> all outputs and counters read 0 and gain_active reads unity during reset and after release.
